vpu_decode_queue: RTL and testbench
===================================

// Module: vpu_decode_queue
// PURPOSE
//  Parametrised multi-entry FIFO between the VPU decoder and the VCFG / instruction-queue
//  consumers. Generalises the single-slot decode buffer to DEPTH entries.
//  Adds a flush that never drops an accepted uOP silently, occupancy status and an LSU-pending count.
//  Sits in the VPU ID stage: decoder -> vpu_decode_queue -> VCFG / instruction queue.
// PARAMETERS
//  DATA_W  64  width of one decoded uOP payload (packed VPU_uOP_t)
//  DEPTH   4   number of entries; >=1; need not be a power of two (DEPTH=1 == legacy single slot)
//  CNT_W   $clog2(DEPTH+1)  derived; width of occupancy counters (not to be overridden)
// PORTS
//  clk_i          in   1       clock, all state updates on rising edge
//  rst_i          in   1       reset, synchronous, active-high
//  in_valid_i     in   1       decoder presents a valid uOP
//  in_data_i      in   DATA_W  decoded uOP
//  in_lsu_i       in   1       uOP targets VLSU (counted in lsu_pending_o)
//  in_ready_o     out  1       queue accepts in_data_i this cycle (handshake = in_valid_i & in_ready_o)
//  out_valid_o    out  1       head entry valid
//  out_data_o     out  DATA_W  head entry payload
//  out_lsu_o      out  1       head entry LSU tag
//  out_ack_i      in   1       consumer takes the head this cycle (ignored when out_valid_o=0)
//  flush_i        in   1       VCFG commit: discard all queued entries
//  count_o        out  CNT_W   number of valid entries
//  lsu_pending_o  out  CNT_W   number of valid entries with LSU tag set
//  empty_o        out  1       count_o == 0
//  full_o         out  1       count_o == DEPTH
// BEHAVIOUR
//  - Storage: DEPTH x (DATA_W+1) array, rd_ptr/wr_ptr wrap from DEPTH-1 to 0, count register.
//  - Reset (rst_i=1 at edge): pointers=0, count=0, lsu count=0, all slots cleared to 0.
//    Outputs then: out_valid_o=0, out_data_o=0, out_lsu_o=0, count_o=0, lsu_pending_o=0,
//    empty_o=1, full_o=0, in_ready_o=1 (if flush_i=0). Reset overrides flush and all handshakes.
//  - Head is combinational from storage: out_valid_o = (count!=0).
//    out_data_o/out_lsu_o = slot[rd_ptr]. Zero-cycle read latency.
//  - in_ready_o = ~flush_i & (~full | (out_ack_i & out_valid_o)). Enqueue into a full queue is
//    allowed when the head leaves in the same cycle (combinational out_ack_i -> in_ready_o path).
//  - deq = out_valid_o & out_ack_i; enq = in_valid_i & in_ready_o.
//  - Enqueue writes slot[wr_ptr], wr_ptr++. Dequeue: rd_ptr++.
//  - count += enq - deq. The LSU count tracks the same way using in_lsu_i / out_lsu_o.
//  - Write latency 1: an entry accepted in cycle N is visible at the head in cycle N+1 (if queue empty).
//    No same-cycle bypass.
//  - Flush (flush_i=1, no reset): next cycle count=0, lsu count=0, rd_ptr=wr_ptr=0.
//    Slot contents are not cleared.
//  - During flush, in_ready_o=0, so no uOP is acknowledged and then lost.
//  - A deq in the flush cycle still completes: the consumer sees the head it acked.
//  - Invariants: 0<=count<=DEPTH; lsu_pending_o<=count_o; full_o and empty_o never both 1.
//  - Enqueue/dequeue order strictly FIFO. Payload passes through unmodified.
// TESTING
//  1 Reset: hold rst_i 2 cycles with in_valid_i=1 -> out_valid_o=0, count_o=0, empty_o=1,
//    in_ready_o=1 after release.
//  2 Fill/drain DEPTH=4: enqueue 0xA0..0xA3 with out_ack_i=0 -> full_o=1, in_ready_o=0.
//    Then ack 4 cycles -> heads A0,A1,A2,A3 in order, empty_o=1.
//  3 Full + simultaneous: full queue, in_valid_i=1 data 0xB0, out_ack_i=1 -> in_ready_o=1,
//    count_o stays 4, 0xB0 emerges after A1..A3.
//  4 Wrap: DEPTH=3, 10 back-to-back enq/deq pairs with data 1..10 -> output order 1..10,
//    count_o never exceeds 3.
//  5 Flush: 3 entries queued (2 LSU), flush_i=1 with in_valid_i=1 -> in_ready_o=0.
//    Next cycle count_o=0, lsu_pending_o=0, out_valid_o=0. A later enqueue of 0xC0 appears at head.
//  6 LSU count: enqueue LSU,ALU,LSU, dequeue one -> lsu_pending_o sequence 1,1,2, then 1 after deq.

Source files
------------

// File: rtl/vpu_decode_queue_if.sv
// Decoder-to-consumer handshake bundle for vpu_decode_queue: uOP in, head out, flush and occupancy status.
interface vpu_decode_queue_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              in_valid_i;
    logic [DATA_W-1:0] in_data_i;
    logic              in_lsu_i;
    logic              in_ready_o;
    logic              out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_lsu_o;
    logic              out_ack_i;
    logic              flush_i;
    logic [CNT_W-1:0]  count_o;
    logic [CNT_W-1:0]  lsu_pending_o;
    logic              empty_o;
    logic              full_o;

    modport master (
        output in_valid_i, in_data_i, in_lsu_i, out_ack_i, flush_i,
        input  in_ready_o, out_valid_o, out_data_o, out_lsu_o,
               count_o, lsu_pending_o, empty_o, full_o
    );

    modport slave (
        input  in_valid_i, in_data_i, in_lsu_i, out_ack_i, flush_i,
        output in_ready_o, out_valid_o, out_data_o, out_lsu_o,
               count_o, lsu_pending_o, empty_o, full_o
    );
endinterface

// File: rtl/vpu_decode_queue.sv
// DEPTH-entry FIFO between the VPU decoder and VCFG / instruction queue, with loss-free flush
// and LSU-pending tracking. Head is read combinationally from storage.
module vpu_decode_queue #(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    vpu_decode_queue_if.slave q
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic              lsu;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           slot_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q, lsu_cnt_q;
    entry_t           head;
    logic             full, deq, enq;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head          = slot_q[rd_ptr_q];
    assign full          = (count_q == CNT_W'(DEPTH));
    assign deq           = (count_q != '0) & q.out_ack_i;
    // Flush blocks acceptance so nothing is acked and then discarded.
    assign q.in_ready_o  = ~q.flush_i & (~full | deq);
    assign enq           = q.in_valid_i & q.in_ready_o;

    assign q.out_valid_o   = (count_q != '0);
    assign q.out_data_o    = head.data;
    assign q.out_lsu_o     = head.lsu;
    assign q.count_o       = count_q;
    assign q.lsu_pending_o = lsu_cnt_q;
    assign q.empty_o       = (count_q == '0);
    assign q.full_o        = full;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            lsu_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
        end else begin
            if (enq) slot_q[wr_ptr_q] <= '{lsu: q.in_lsu_i, data: q.in_data_i};
            if (q.flush_i) begin
                rd_ptr_q  <= '0;
                wr_ptr_q  <= '0;
                count_q   <= '0;
                lsu_cnt_q <= '0;
            end else begin
                if (enq) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (deq) rd_ptr_q <= ptr_inc(rd_ptr_q);
                count_q   <= count_q + CNT_W'(enq) - CNT_W'(deq);
                lsu_cnt_q <= lsu_cnt_q + CNT_W'(enq & q.in_lsu_i) - CNT_W'(deq & head.lsu);
            end
        end
    end
endmodule

// File: tb/tb_vpu_decode_queue.sv
// Scoreboard bench for vpu_decode_queue: DEPTH=4 instance for most scenarios, DEPTH=3 for wrap.
module tb_vpu_decode_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vpu_decode_queue_if #(.DATA_W(64), .DEPTH(4)) qa ();
    vpu_decode_queue_if #(.DATA_W(16), .DEPTH(3)) qb ();

    vpu_decode_queue #(.DATA_W(64), .DEPTH(4)) u_a (.clk_i(clk), .rst_i(rst), .q(qa.slave));
    vpu_decode_queue #(.DATA_W(16), .DEPTH(3)) u_b (.clk_i(clk), .rst_i(rst), .q(qb.slave));

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] sb [$];
    logic [63:0] exp_d;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_a(input int n, input logic [63:0] base, input logic [3:0] mask);
        for (int i = 0; i < n; i++) begin
            qa.in_valid_i = 1'b1;
            qa.in_data_i  = base + 64'(i);
            qa.in_lsu_i   = mask[i];
            sb.push_back(base + 64'(i));
            step();
        end
        qa.in_valid_i = 1'b0;
        qa.in_lsu_i   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        qa.in_valid_i = 1'b1; qa.in_data_i = 64'h55; qb.in_valid_i = 1'b1; qb.in_data_i = 16'h55;
        step();
        step();
        rst = 1'b0;
        qa.in_valid_i = 1'b0; qb.in_valid_i = 1'b0;
        #1;
        n_cmp++; if (qa.out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", qa.out_valid_o); end
        n_cmp++; if (qa.count_o !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", qa.count_o); end
        n_cmp++; if (qa.empty_o !== 1'b1 || qa.full_o !== 1'b0) begin n_err++; $display("FAIL reset_flags: empty %b full %b want 1 0", qa.empty_o, qa.full_o); end
        n_cmp++; if (qa.in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", qa.in_ready_o); end
        n_cmp++; if (qa.out_data_o !== 64'h0 || qa.out_lsu_o !== 1'b0 || qa.lsu_pending_o !== 3'd0) begin
            n_err++; $display("FAIL reset_head: data %h lsu %b pend %0d want 0 0 0", qa.out_data_o, qa.out_lsu_o, qa.lsu_pending_o); end
        n_cmp++; if (qb.count_o !== 2'd0 || qb.in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_b: count %0d ready %b want 0 1", qb.count_o, qb.in_ready_o); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            qa.in_valid_i = 1'b1; qa.in_data_i = 64'hA0 + 64'(i);
            #1;
            n_cmp++; if (qa.in_ready_o !== 1'b1) begin n_err++; $display("FAIL fill_ready[%0d]: got %b want 1", i, qa.in_ready_o); end
            if (i == 0) begin
                n_cmp++; if (qa.out_valid_o !== 1'b0) begin n_err++; $display("FAIL no_bypass: got %b want 0", qa.out_valid_o); end
            end
            sb.push_back(64'hA0 + 64'(i));
            step();
        end
        qa.in_data_i = 64'hFF;
        #1;
        n_cmp++; if (qa.full_o !== 1'b1 || qa.in_ready_o !== 1'b0) begin n_err++; $display("FAIL full_flags: full %b ready %b want 1 0", qa.full_o, qa.in_ready_o); end
        n_cmp++; if (qa.count_o !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", qa.count_o); end
        step();
        qa.in_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            qa.out_ack_i = 1'b1;
            #1;
            exp_d = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
            n_cmp++; if (qa.out_valid_o !== 1'b1 || qa.out_data_o !== exp_d) begin
                n_err++; $display("FAIL drain_head[%0d]: valid %b data %h want 1 %h", i, qa.out_valid_o, qa.out_data_o, exp_d); end
            step();
        end
        qa.out_ack_i = 1'b0;
        #1;
        n_cmp++; if (qa.empty_o !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", qa.empty_o); end
    endtask

    task automatic test_full_simul();
        fill_a(4, 64'hA0, 4'b0000);
        qa.in_valid_i = 1'b1; qa.in_data_i = 64'hB0; qa.out_ack_i = 1'b1;
        #1;
        n_cmp++; if (qa.in_ready_o !== 1'b1) begin n_err++; $display("FAIL simul_ready: got %b want 1", qa.in_ready_o); end
        exp_d = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
        n_cmp++; if (qa.out_data_o !== exp_d) begin n_err++; $display("FAIL simul_head: got %h want %h", qa.out_data_o, exp_d); end
        sb.push_back(64'hB0);
        step();
        qa.in_valid_i = 1'b0; qa.out_ack_i = 1'b0;
        #1;
        n_cmp++; if (qa.count_o !== 3'd4) begin n_err++; $display("FAIL simul_count: got %0d want 4", qa.count_o); end
        for (int i = 0; i < 4; i++) begin
            qa.out_ack_i = 1'b1;
            #1;
            exp_d = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
            n_cmp++; if (qa.out_valid_o !== 1'b1 || qa.out_data_o !== exp_d) begin
                n_err++; $display("FAIL simul_drain[%0d]: valid %b data %h want 1 %h", i, qa.out_valid_o, qa.out_data_o, exp_d); end
            step();
        end
        qa.out_ack_i = 1'b0;
        #1;
        n_cmp++; if (qa.empty_o !== 1'b1) begin n_err++; $display("FAIL simul_empty: got %b want 1", qa.empty_o); end
    endtask

    task automatic test_wrap();
        int rcv = 0;
        int maxc = 0;
        for (int k = 1; k <= 10; k++) begin
            qb.in_valid_i = 1'b1; qb.in_data_i = 16'(k); qb.out_ack_i = (k >= 4);
            #1;
            if (qb.out_valid_o && qb.out_ack_i) begin
                exp_d = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
                n_cmp++; if (qb.out_data_o !== exp_d[15:0]) begin n_err++; $display("FAIL wrap_head[%0d]: got %0d want %0d", rcv, qb.out_data_o, exp_d[15:0]); end
                rcv++;
            end
            n_cmp++; if (qb.in_ready_o !== 1'b1) begin n_err++; $display("FAIL wrap_ready[%0d]: got %b want 1", k, qb.in_ready_o); end
            if (int'(qb.count_o) > maxc) maxc = int'(qb.count_o);
            sb.push_back(64'(k));
            step();
        end
        qb.in_valid_i = 1'b0;
        for (int i = 0; i < 6 && sb.size() > 0; i++) begin
            qb.out_ack_i = 1'b1;
            #1;
            if (qb.out_valid_o) begin
                exp_d = sb.pop_front();
                n_cmp++; if (qb.out_data_o !== exp_d[15:0]) begin n_err++; $display("FAIL wrap_tail[%0d]: got %0d want %0d", rcv, qb.out_data_o, exp_d[15:0]); end
                rcv++;
            end
            step();
        end
        qb.out_ack_i = 1'b0;
        #1;
        n_cmp++; if (rcv != 10) begin n_err++; $display("FAIL wrap_total: got %0d want 10", rcv); end
        n_cmp++; if (maxc != 3) begin n_err++; $display("FAIL wrap_maxcount: got %0d want 3", maxc); end
        n_cmp++; if (qb.empty_o !== 1'b1) begin n_err++; $display("FAIL wrap_empty: got %b want 1", qb.empty_o); end
        sb.delete();
    endtask

    task automatic test_flush();
        fill_a(3, 64'hD0, 4'b0101);
        #1;
        n_cmp++; if (qa.count_o !== 3'd3 || qa.lsu_pending_o !== 3'd2) begin
            n_err++; $display("FAIL preflush: count %0d lsu %0d want 3 2", qa.count_o, qa.lsu_pending_o); end
        qa.flush_i = 1'b1; qa.in_valid_i = 1'b1; qa.in_data_i = 64'hEE; qa.out_ack_i = 1'b1;
        #1;
        n_cmp++; if (qa.in_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", qa.in_ready_o); end
        exp_d = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
        n_cmp++; if (qa.out_valid_o !== 1'b1 || qa.out_data_o !== exp_d) begin
            n_err++; $display("FAIL flush_deq: valid %b data %h want 1 %h", qa.out_valid_o, qa.out_data_o, exp_d); end
        step();
        qa.flush_i = 1'b0; qa.in_valid_i = 1'b0; qa.out_ack_i = 1'b0;
        sb.delete();
        #1;
        n_cmp++; if (qa.count_o !== 3'd0 || qa.lsu_pending_o !== 3'd0 || qa.out_valid_o !== 1'b0) begin
            n_err++; $display("FAIL postflush: count %0d lsu %0d valid %b want 0 0 0", qa.count_o, qa.lsu_pending_o, qa.out_valid_o); end
        qa.in_valid_i = 1'b1; qa.in_data_i = 64'hC0;
        sb.push_back(64'hC0);
        step();
        qa.in_valid_i = 1'b0;
        #1;
        exp_d = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
        n_cmp++; if (qa.out_valid_o !== 1'b1 || qa.out_data_o !== exp_d || qa.count_o !== 3'd1) begin
            n_err++; $display("FAIL flush_reenq: valid %b data %h count %0d want 1 %h 1", qa.out_valid_o, qa.out_data_o, qa.count_o, exp_d); end
        qa.out_ack_i = 1'b1;
        step();
        qa.out_ack_i = 1'b0;
    endtask

    task automatic test_lsu();
        logic [2:0] exp_l [3];
        exp_l[0] = 3'd1; exp_l[1] = 3'd1; exp_l[2] = 3'd2;
        for (int i = 0; i < 3; i++) begin
            qa.in_valid_i = 1'b1; qa.in_data_i = 64'hE0 + 64'(i); qa.in_lsu_i = (i != 1);
            sb.push_back(64'hE0 + 64'(i));
            step();
            n_cmp++; if (qa.lsu_pending_o !== exp_l[i]) begin n_err++; $display("FAIL lsu_seq[%0d]: got %0d want %0d", i, qa.lsu_pending_o, exp_l[i]); end
        end
        qa.in_valid_i = 1'b0; qa.in_lsu_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            qa.out_ack_i = 1'b1;
            #1;
            exp_d = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
            n_cmp++; if (qa.out_data_o !== exp_d || qa.out_lsu_o !== (i != 1)) begin
                n_err++; $display("FAIL lsu_head[%0d]: data %h lsu %b want %h %b", i, qa.out_data_o, qa.out_lsu_o, exp_d, (i != 1)); end
            step();
            if (i == 0) begin
                qa.out_ack_i = 1'b0;
                #1;
                n_cmp++; if (qa.lsu_pending_o !== 3'd1 || qa.count_o !== 3'd2) begin
                    n_err++; $display("FAIL lsu_after_deq: lsu %0d count %0d want 1 2", qa.lsu_pending_o, qa.count_o); end
            end
        end
        qa.out_ack_i = 1'b0;
        #1;
        n_cmp++; if (qa.lsu_pending_o !== 3'd0 || qa.empty_o !== 1'b1) begin
            n_err++; $display("FAIL lsu_drained: lsu %0d empty %b want 0 1", qa.lsu_pending_o, qa.empty_o); end
    endtask

    initial begin
        qa.in_valid_i = 1'b0; qa.in_data_i = '0; qa.in_lsu_i = 1'b0; qa.out_ack_i = 1'b0; qa.flush_i = 1'b0;
        qb.in_valid_i = 1'b0; qb.in_data_i = '0; qb.in_lsu_i = 1'b0; qb.out_ack_i = 1'b0; qb.flush_i = 1'b0;
        test_reset();
        test_fill_drain();
        test_full_simul();
        test_wrap();
        test_flush();
        test_lsu();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end
endmodule
